// File: rtl/mfp_ahb_lite_master_pkg.sv
// rtl/mfp_ahb_lite_master_pkg.sv - shared AHB-Lite encodings and stage types for the master bridge
package mfp_ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_8       = 3'b000;
    localparam logic [2:0] HSIZE_16      = 3'b001;
    localparam logic [2:0] HSIZE_32      = 3'b010;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } a_stage_t;

    localparam a_stage_t A_STAGE_RESET = '{valid: 1'b0, addr: 32'd0, write: 1'b0,
                                           size: HSIZE_32, wdata: 32'd0};

endpackage

// File: rtl/mfp_ahb_lite_master_lanes.sv
// rtl/mfp_ahb_lite_master_lanes.sv - little-endian write lane replication and read lane extraction
module mfp_ahb_lite_master_lanes
    import mfp_ahb_lite_master_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] bus_rdata,
    output logic [31:0] hwdata,
    output logic [31:0] rdata
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = bus_rdata >> {addr_lo, 3'b000};
    assign half_shift = bus_rdata >> {addr_lo[1], 4'b0000};

    always_comb begin
        hwdata = wdata;
        rdata  = bus_rdata;
        case (size)
            HSIZE_8: begin
                hwdata = {4{wdata[7:0]}};
                rdata  = {24'd0, byte_shift[7:0]};
            end
            HSIZE_16: begin
                hwdata = {2{wdata[15:0]}};
                rdata  = {16'd0, half_shift[15:0]};
            end
            default: begin
                hwdata = wdata;
                rdata  = bus_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mfp_ahb_lite_master.sv
// rtl/mfp_ahb_lite_master.sv - request stream to pipelined AHB-Lite SINGLE transfers
// Optional byte-lane steering: MFP_AHB_MASTER_BYTE_LANE_EN
module mfp_ahb_lite_master
    import mfp_ahb_lite_master_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    a_stage_t    a_q;
    a_stage_t    req_stage;
    logic        d_valid;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        err1_q;
    logic        oor_q;
    logic        accept;
    logic        complete;
    logic        bus_err;
    logic [31:0] hwdata_w;
    logic [31:0] rd_data;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;

    assign req_ready = oor_q & (~a_q.valid | (HREADY & ~err1_q));
    assign accept    = req_valid & req_ready;
    assign complete  = HREADY & d_valid;
    // err1 marks the second ERROR cycle; HRESP alone with HREADY is the protocol-violation case
    assign bus_err   = err1_q | HRESP;
    assign req_stage = '{valid: 1'b1, addr: req_addr, write: req_write,
                         size: req_size, wdata: req_wdata};

`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
    logic [1:0] d_addr_lo;
    logic [2:0] d_size;

    mfp_ahb_lite_master_lanes u_lanes (
        .wdata     (d_wdata),
        .size      (d_size),
        .addr_lo   (d_addr_lo),
        .bus_rdata (HRDATA),
        .hwdata    (hwdata_w),
        .rdata     (rd_data)
    );
`else
    assign hwdata_w = d_wdata;
    assign rd_data  = HRDATA;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            oor_q       <= 1'b0;
            err1_q      <= 1'b0;
            a_q         <= A_STAGE_RESET;
            d_valid     <= 1'b0;
            d_write     <= 1'b0;
            d_wdata     <= 32'd0;
`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
            d_addr_lo   <= 2'd0;
            d_size      <= HSIZE_32;
`endif
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            oor_q       <= 1'b1;
            rsp_valid_q <= complete;
            rsp_error_q <= complete & bus_err;
            rsp_rdata_q <= (complete & ~bus_err & ~d_write) ? rd_data : 32'd0;
            if (HREADY) begin
                err1_q <= 1'b0;
                if (err1_q) begin
                    // A stays put so it is re-driven as NONSEQ after the error completes
                    d_valid <= 1'b0;
                    if (accept) begin
                        a_q <= req_stage;
                    end
                end else begin
                    d_valid   <= a_q.valid;
                    d_write   <= a_q.write;
                    d_wdata   <= a_q.wdata;
`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
                    d_addr_lo <= a_q.addr[1:0];
                    d_size    <= a_q.size;
`endif
                    if (accept) begin
                        a_q <= req_stage;
                    end else begin
                        a_q.valid <= 1'b0;
                    end
                end
            end else begin
                if (d_valid & HRESP) begin
                    err1_q <= 1'b1;
                end
                if (accept) begin
                    a_q <= req_stage;
                end
            end
        end
    end

    assign HTRANS    = (a_q.valid & ~err1_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_q.addr;
    assign HWRITE    = a_q.write;
    assign HSIZE     = a_q.size;
    assign HWDATA    = hwdata_w;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// tb/tb_mfp_ahb_lite_master.sv - self-checking bench for mfp_ahb_lite_master
module tb_mfp_ahb_lite_master;

    logic        HCLK;
    logic        HRESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    mfp_ahb_lite_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Expected bus write data and returned read data, by little-endian lane arithmetic
    function automatic logic [31:0] exp_hw(logic [31:0] w, logic [2:0] s);
`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
        if (s == 3'd0) return {24'd0, w[7:0]} * 32'h01010101;
        if (s == 3'd1) return {16'd0, w[15:0]} * 32'h00010001;
`endif
        return w;
    endfunction

    function automatic logic [31:0] exp_rd(logic [31:0] h, logic [31:0] a, logic [2:0] s);
`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
        if (s == 3'd0) return (h >> (8 * a[1:0])) & 32'hFF;
        if (s == 3'd1) return (h >> (16 * a[1])) & 32'hFFFF;
`endif
        return h;
    endfunction

    task automatic test_reset();
        HRESETn = 1'b0; req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_write = 1'b1;
        req_size = 3'd0; req_wdata = 32'hFFFF_FFFF; HRDATA = 32'hFFFF_FFFF; HREADY = 1'b1; HRESP = 1'b0;
        step(); step();
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %h want 0", HTRANS); end
        checks++; if (HADDR !== 32'd0) begin errors++; $display("FAIL reset_haddr: got %h want 0", HADDR); end
        checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL reset_hwrite: got %b want 0", HWRITE); end
        checks++; if (HSIZE !== 3'b010) begin errors++; $display("FAIL reset_hsize: got %h want 2", HSIZE); end
        checks++; if (HWDATA !== 32'd0) begin errors++; $display("FAIL reset_hwdata: got %h want 0", HWDATA); end
        checks++; if ({rsp_valid, rsp_error} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b%b want 00", rsp_valid, rsp_error); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin errors++; $display("FAIL reset_consts: got %h/%b/%h want 0/0/3", HBURST, HMASTLOCK, HPROT); end
        req_write = 1'b0; req_size = 3'd2;
        HRESETn = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", req_ready); end
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read_zero_wait();
        step();
        req_valid = 1'b1; req_addr = 32'hBFC0_0000; req_write = 1'b0; req_size = 3'd2; req_wdata = 32'd0;
        HREADY = 1'b1; HRESP = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", req_ready); end
        step(); req_valid = 1'b0; #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'hBFC0_0000 || HWRITE !== 1'b0 || HSIZE !== 3'd2) begin
            errors++; $display("FAIL rd_addr_phase: got %h %h %b %h want 2 bfc00000 0 2", HTRANS, HADDR, HWRITE, HSIZE); end
        step(); HRDATA = 32'h1234_5678; #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_data_phase: got htrans %h rsp %b want 0 0", HTRANS, rsp_valid); end
        step(); HRDATA = 32'hCAFE_0000; #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: got %b %h %b want 1 12345678 0", rsp_valid, rsp_rdata, rsp_error); end
        step(); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_write_wait();
        step();
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_write = 1'b1; req_size = 3'd2; req_wdata = 32'hDEAD_BEEF;
        HREADY = 1'b1; HRDATA = 32'h5555_5555;
        step(); req_valid = 1'b0; #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h8000_0010 || HWRITE !== 1'b1) begin
            errors++; $display("FAIL wr_addr_phase: got %h %h %b want 2 80000010 1", HTRANS, HADDR, HWRITE); end
        step();
        for (int i = 0; i < 4; i++) begin
            HREADY = (i == 3); #1;
            checks++; if (HWDATA !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL wr_wait%0d: got hwdata %h rsp %b want deadbeef 0", i, HWDATA, rsp_valid); end
            step();
        end
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_error !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: got %b %h %b want 1 0 0", rsp_valid, rsp_rdata, rsp_error); end
        step(); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr [4];
        logic [31:0] data [4];
        for (int j = 0; j < 4; j++) begin
            addr[j] = $urandom & 32'hFFFF_FFFC;
            data[j] = $urandom;
        end
        step();
        req_valid = 1'b1; req_addr = addr[0]; req_write = 1'b0; req_size = 3'd2; HREADY = 1'b1; HRESP = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k < 3) req_addr = addr[k + 1];
            else req_valid = 1'b0;
            // transfer j: NONSEQ in cycle j, data phase in j+1, response in j+2
            HRDATA = (k >= 1 && k <= 4) ? data[k - 1] : 32'hA5A5_0000;
            #1;
            if (k < 4) begin
                checks++; if (HTRANS !== 2'b10 || HADDR !== addr[k]) begin
                    errors++; $display("FAIL b2b_addr%0d: got %h %h want 2 %h", k, HTRANS, HADDR, addr[k]); end
            end else begin
                checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL b2b_idle%0d: got %h want 0", k, HTRANS); end
            end
            if (k >= 2 && k <= 5) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== data[k - 2]) begin
                    errors++; $display("FAIL b2b_rsp%0d: got %b %h want 1 %h", k, rsp_valid, rsp_rdata, data[k - 2]); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_norsp%0d: got %b want 0", k, rsp_valid); end
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] a1, a2, x2;
        a1 = 32'h2000_0100; a2 = 32'h2000_0204; x2 = 32'h0BAD_F00D;
        step();
        req_valid = 1'b1; req_addr = a1; req_write = 1'b0; req_size = 3'd2;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hFFFF_0000; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL err_ready0: got %b want 1", req_ready); end
        step(); req_addr = a2; #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== a1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL err_t1_addr: got %h %h %b want 2 %h 1", HTRANS, HADDR, req_ready, a1); end
        step(); req_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1; #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== a2 || req_ready !== 1'b0) begin
            errors++; $display("FAIL err_cycle1: got %h %h %b want 2 %h 0", HTRANS, HADDR, req_ready, a2); end
        step(); HREADY = 1'b1; HRESP = 1'b1; #1;
        checks++; if (HTRANS !== 2'b00 || HADDR !== a2 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL err_cycle2: got %h %h %b %b want 0 %h 0 0", HTRANS, HADDR, rsp_valid, req_ready, a2); end
        step(); HRESP = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL err_rsp: got %b %b %h want 1 1 0", rsp_valid, rsp_error, rsp_rdata); end
        checks++; if (HTRANS !== 2'b10 || HADDR !== a2) begin
            errors++; $display("FAIL err_reissue: got %h %h want 2 %h", HTRANS, HADDR, a2); end
        step(); HRDATA = x2; #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL err_t2_data: got %h %b want 0 0", HTRANS, rsp_valid); end
        step(); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== x2) begin
            errors++; $display("FAIL err_t2_rsp: got %b %b %h want 1 0 %h", rsp_valid, rsp_error, rsp_rdata, x2); end
    endtask

    task automatic test_reset_mid();
        step();
        req_valid = 1'b1; req_addr = 32'h4000_0000; req_write = 1'b1; req_size = 3'd2; req_wdata = 32'h1111_2222;
        HREADY = 1'b1; HRESP = 1'b0;
        step(); req_addr = 32'h4000_0008; req_write = 1'b0;
        step(); req_valid = 1'b0; HREADY = 1'b0; #1;
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rstmid_pre: got %h want 2", HTRANS); end
        HRESETn = 1'b0; #1;
        checks++; if (HTRANS !== 2'b00 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got %h %b %b want 0 0 0", HTRANS, req_ready, rsp_valid); end
        step(); HREADY = 1'b1; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_norsp: got %b want 0", rsp_valid); end
        step(); HRESETn = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_early: got %b want 0", req_ready); end
        step(); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
                errors++; $display("FAIL rstmid_quiet%0d: got %b %h want 0 0", i, rsp_valid, HTRANS); end
        end
    endtask

`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
    task automatic test_byte_lanes();
        step();
        req_valid = 1'b1; req_addr = 32'h0000_0002; req_write = 1'b1; req_size = 3'd0; req_wdata = 32'h0000_00A5;
        HREADY = 1'b1; HRESP = 1'b0;
        step(); req_addr = 32'h0000_0003; req_write = 1'b0; req_wdata = 32'd0;
        step(); req_valid = 1'b0; #1;
        checks++; if (HWDATA !== 32'hA5A5_A5A5) begin errors++; $display("FAIL lane_wr: got %h want a5a5a5a5", HWDATA); end
        step(); HRDATA = 32'h1234_5678;
        step(); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0012) begin
            errors++; $display("FAIL lane_rd: got %b %h want 1 00000012", rsp_valid, rsp_rdata); end
    endtask
`endif

    task automatic test_random();
        txn_t q[$];
        txn_t cur, dp;
        logic dp_pending, exp_v, acc, hr;
        logic [31:0] exp_d, hd, ha;
        logic [1:0] tr;
        logic hw;
        logic [2:0] hs;
        int n_acc, n_done;
        dp_pending = 1'b0; exp_v = 1'b0; exp_d = 32'd0; n_acc = 0; n_done = 0;
        dp = '{addr: 32'd0, write: 1'b0, size: 3'd2, wdata: 32'd0};
        for (int i = 0; i < 700; i++) begin
            step();
            HREADY = ($urandom_range(0, 3) != 0);
            HRESP = 1'b0;
            HRDATA = $urandom;
            cur.size = 3'($urandom_range(0, 2));
            cur.addr = $urandom & ~((32'd1 << cur.size) - 32'd1);
            cur.write = $urandom_range(0, 1);
            cur.wdata = $urandom;
            req_valid = (i < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_addr = cur.addr; req_write = cur.write; req_size = cur.size; req_wdata = cur.wdata;
            #1;
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", i, rsp_valid, exp_v); end
            else if (exp_v) begin
                checks++; if (rsp_rdata !== exp_d || rsp_error !== 1'b0) begin
                    errors++; $display("FAIL rnd_rsp_data@%0d: got %h %b want %h 0", i, rsp_rdata, rsp_error, exp_d); end
            end
            if (dp_pending && dp.write) begin
                checks++; if (HWDATA !== exp_hw(dp.wdata, dp.size)) begin
                    errors++; $display("FAIL rnd_hwdata@%0d: got %h want %h", i, HWDATA, exp_hw(dp.wdata, dp.size)); end
            end
            acc = req_valid & req_ready; tr = HTRANS; ha = HADDR; hw = HWRITE; hs = HSIZE; hr = HREADY; hd = HRDATA;
            // slave view of the coming edge: data phase completes, address phase is taken
            exp_v = 1'b0;
            if (hr) begin
                if (dp_pending) begin
                    exp_v = 1'b1;
                    exp_d = dp.write ? 32'd0 : exp_rd(hd, dp.addr, dp.size);
                    dp_pending = 1'b0;
                    n_done++;
                end
                if (tr == 2'b10) begin
                    if (q.size() == 0) begin
                        checks++; errors++; $display("FAIL rnd_spurious@%0d: got NONSEQ %h want no transfer", i, ha);
                    end else begin
                        dp = q.pop_front();
                        checks++; if (ha !== dp.addr || hw !== dp.write || hs !== dp.size) begin
                            errors++; $display("FAIL rnd_addr@%0d: got %h %b %h want %h %b %h", i, ha, hw, hs, dp.addr, dp.write, dp.size); end
                        dp_pending = 1'b1;
                    end
                end else if (tr !== 2'b00) begin
                    checks++; errors++; $display("FAIL rnd_htrans@%0d: got %h want 0 or 2", i, tr);
                end
            end
            if (acc) begin
                q.push_back(cur);
                n_acc++;
            end
            if (i >= 400 && q.size() == 0 && !dp_pending && !exp_v) break;
        end
        checks++; if (q.size() != 0 || dp_pending || n_done != n_acc || n_acc == 0) begin
            errors++; $display("FAIL rnd_drain: got done %0d pending %0d want done %0d pending 0", n_done, q.size(), n_acc); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_back_to_back();
        test_error();
        test_reset_mid();
`ifdef MFP_AHB_MASTER_BYTE_LANE_EN
        test_byte_lanes();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
